// File: rtl/complex_pkg.sv
//==============================================================================
// Module      : complex_pkg
// Description : Shared mode encodings and output-width helper for complex_mac.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package complex_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // Two 2W-bit products summed, then up to acc_len results accumulated.
  function automatic int calc_ow(input int w, input int acc_len);
    return 2 * w + 1 + $clog2(acc_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/complex_mult_stage.sv
//==============================================================================
// Module      : complex_mult_stage
// Description : First pipeline stage; registers the four signed partial products.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module complex_mult_stage #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic signed [W-1:0]   a_real,
  input  logic signed [W-1:0]   a_imag,
  input  logic signed [W-1:0]   b_real,
  input  logic signed [W-1:0]   b_imag,
  output logic signed [2*W-1:0] p_rr,
  output logic signed [2*W-1:0] p_ii,
  output logic signed [2*W-1:0] p_ri,
  output logic signed [2*W-1:0] p_ir
);

  logic signed [2*W-1:0] w_ar;
  logic signed [2*W-1:0] w_ai;
  logic signed [2*W-1:0] w_br;
  logic signed [2*W-1:0] w_bi;

  // Operands widened first so each product is formed at its full 2W width.
  assign w_ar = {{W{a_real[W-1]}}, a_real};
  assign w_ai = {{W{a_imag[W-1]}}, a_imag};
  assign w_br = {{W{b_real[W-1]}}, b_real};
  assign w_bi = {{W{b_imag[W-1]}}, b_imag};

  always_ff @(posedge clk) begin
    if (rst) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (load) begin
      p_rr <= w_ar * w_br;
      p_ii <= w_ai * w_bi;
      p_ri <= w_ar * w_bi;
      p_ir <= w_ai * w_br;
    end
  end

endmodule

`default_nettype wire

// File: rtl/complex_mac.sv
//==============================================================================
// Module      : complex_mac
// Description : Two-stage complex multiplier / accumulator with valid-ready flow.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module complex_mac
  import complex_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int ACC_LEN = 4,
  localparam int OW      = calc_ow(W, ACC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  a_real,
  input  logic signed [W-1:0]  a_imag,
  input  logic signed [W-1:0]  b_real,
  input  logic signed [W-1:0]  b_imag,
  input  logic                 conj_b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] z_real,
  output logic signed [OW-1:0] z_imag
);

  localparam int            c_cw   = $clog2(ACC_LEN);
  localparam logic [c_cw-1:0] c_last = c_cw'(ACC_LEN - 1);

  logic w_en;
  logic w_accept;
  logic w_first;
  logic w_beat_mode;
  logic w_beat_last;

  logic [c_cw-1:0] r_cnt;
  logic            r_mode;
  logic            r_s1_valid;
  logic            r_s1_mode;
  logic            r_s1_conj;
  logic            r_s1_last;
  logic            r_s1_first;
  logic            r_out_valid;
  logic signed [OW-1:0] r_acc_real;
  logic signed [OW-1:0] r_acc_imag;
  logic signed [OW-1:0] r_z_real;
  logic signed [OW-1:0] r_z_imag;

  logic signed [2*W-1:0] w_p_rr;
  logic signed [2*W-1:0] w_p_ii;
  logic signed [2*W-1:0] w_p_ri;
  logic signed [2*W-1:0] w_p_ir;
  logic signed [OW-1:0]  w_rr;
  logic signed [OW-1:0]  w_ii;
  logic signed [OW-1:0]  w_ri;
  logic signed [OW-1:0]  w_ir;
  logic signed [OW-1:0]  w_sum_real;
  logic signed [OW-1:0]  w_sum_imag;
  logic signed [OW-1:0]  w_acc_real;
  logic signed [OW-1:0]  w_acc_imag;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en && !rst;
  assign w_accept = in_valid && in_ready;

  // Mode is only sampled on a group's first beat; later beats follow the latch.
  assign w_first     = (r_cnt == '0);
  assign w_beat_mode = w_first ? mode : r_mode;
  assign w_beat_last = (w_beat_mode == MODE_MUL) || (r_cnt == c_last);

  complex_mult_stage #(
    .W (W)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .a_real (a_real),
    .a_imag (a_imag),
    .b_real (b_real),
    .b_imag (b_imag),
    .p_rr   (w_p_rr),
    .p_ii   (w_p_ii),
    .p_ri   (w_p_ri),
    .p_ir   (w_p_ir)
  );

  assign w_rr = {{(OW-2*W){w_p_rr[2*W-1]}}, w_p_rr};
  assign w_ii = {{(OW-2*W){w_p_ii[2*W-1]}}, w_p_ii};
  assign w_ri = {{(OW-2*W){w_p_ri[2*W-1]}}, w_p_ri};
  assign w_ir = {{(OW-2*W){w_p_ir[2*W-1]}}, w_p_ir};

  assign w_sum_real = r_s1_conj ? (w_rr + w_ii) : (w_rr - w_ii);
  assign w_sum_imag = r_s1_conj ? (w_ir - w_ri) : (w_ir + w_ri);
  assign w_acc_real = r_s1_first ? w_sum_real : (r_acc_real + w_sum_real);
  assign w_acc_imag = r_s1_first ? w_sum_imag : (r_acc_imag + w_sum_imag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_mode      <= MODE_MUL;
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= MODE_MUL;
      r_s1_conj   <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_first  <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc_real  <= '0;
      r_acc_imag  <= '0;
      r_z_real    <= '0;
      r_z_imag    <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mode  <= w_beat_mode;
        r_s1_conj  <= conj_b;
        r_s1_last  <= w_beat_last;
        r_s1_first <= w_first;
        if (w_first) begin
          r_mode <= mode;
        end
        if (w_beat_mode == MODE_ACC) begin
          r_cnt <= w_beat_last ? '0 : r_cnt + c_cw'(1);
        end
      end

      r_out_valid <= 1'b0;
      if (r_s1_valid) begin
        if (r_s1_mode == MODE_ACC) begin
          r_acc_real <= w_acc_real;
          r_acc_imag <= w_acc_imag;
          if (r_s1_last) begin
            r_out_valid <= 1'b1;
            r_z_real    <= w_acc_real;
            r_z_imag    <= w_acc_imag;
          end
        end else begin
          r_out_valid <= 1'b1;
          r_z_real    <= w_sum_real;
          r_z_imag    <= w_sum_imag;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign z_real    = r_z_real;
  assign z_imag    = r_z_imag;

endmodule

`default_nettype wire
